alu_div_sequencer: RTL and testbench

//  Multi-cycle sequencer for RV32M DIV/DIVU/REM/REMU that owns the shared 32-bit
//  ALU for the duration of a divide.
//  - Runs restoring division one quotient bit per iteration.
//  - Drives the ALU with LTU (compare) and SUB (restore) operations.
//  - Sits beside the execute stage; the ALU operand mux selects this block while busy=1.

---
 rtl/alu_div_sequencer.sv | 172 +++++++++++++++++
 tb/tb_alu_div_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_div_sequencer.sv
// alu_div_sequencer: multi-cycle RV32M DIV/DIVU/REM/REMU sequencer that borrows
// the shared execute-stage ALU while busy, producing one quotient bit per
// iteration by restoring division (LTU compare, then SUB restore when needed).
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start, op           request (sampled only when idle); 00 DIV 01 DIVU 10 REM 11 REMU
//   dividend, divisor   rs1 / rs2, captured with start
//   flush               synchronous abort back to idle, result untouched
//   busy                high whenever not idle (ALU mux select)
//   done, result        one-cycle completion pulse and held result
//   alu_op/alu_a/alu_b  operation and operands driven to the shared ALU
//   alu_result, alu_ltu same-cycle ALU difference and unsigned less-than flag
module alu_div_sequencer #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          FAST_SPEC = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_ltu
);

  localparam int unsigned CNT_W = 5;
  localparam logic [3:0]  ALU_ADD = 4'd0;
  localparam logic [3:0]  ALU_SUB = 4'd1;
  localparam logic [3:0]  ALU_LTU = 4'd2;
  localparam logic [WIDTH-1:0] W_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] W_ONES = {WIDTH{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_CMP, S_SUB, S_FIN} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_dvd;
  logic [WIDTH-1:0]   r_dsr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_is_rem;

  // Operand conditioning at capture time
  logic               w_signed;
  logic               w_dvd_neg;
  logic               w_dsr_neg;
  logic [WIDTH-1:0]   w_dvd_abs;
  logic [WIDTH-1:0]   w_dsr_abs;
  logic               w_div_zero;
  logic               w_ovf;
  logic               w_special;
  logic [WIDTH-1:0]   w_shifted;
  logic               w_last;

  assign w_signed   = ~op[0];
  assign w_dvd_neg  = w_signed & dividend[WIDTH-1];
  assign w_dsr_neg  = w_signed & divisor[WIDTH-1];
  assign w_dvd_abs  = w_dvd_neg ? (~dividend + WIDTH'(1)) : dividend;
  assign w_dsr_abs  = w_dsr_neg ? (~divisor + WIDTH'(1)) : divisor;
  assign w_div_zero = (divisor == '0);
  assign w_ovf      = w_signed & (dividend == W_MIN) & (divisor == W_ONES);
  assign w_special  = FAST_SPEC & (w_div_zero | w_ovf);
  assign w_shifted  = {r_rem[WIDTH-2:0], r_dvd[WIDTH-1]};
  assign w_last     = (r_cnt == '0);
  assign busy       = (r_state != S_IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and ALU drive
  always_comb begin
    w_state_nxt = r_state;
    alu_op      = ALU_ADD;
    alu_a       = '0;
    alu_b       = '0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = w_special ? S_FIN : S_CMP;
      end
      S_CMP: begin
        alu_op = ALU_LTU;
        alu_a  = w_shifted;
        alu_b  = r_dsr;
        if (!alu_ltu)    w_state_nxt = S_SUB;
        else if (w_last) w_state_nxt = S_FIN;
      end
      S_SUB: begin
        alu_op      = ALU_SUB;
        alu_a       = r_rem;
        alu_b       = r_dsr;
        w_state_nxt = w_last ? S_FIN : S_CMP;
      end
      S_FIN: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  // Datapath: capture, shift/compare, restore, sign fix-up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvd    <= '0;
      r_dsr    <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_rem <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
    end else begin
      done <= 1'b0;
      if (!flush) begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_dvd    <= w_dvd_abs;
              r_dsr    <= w_dsr_abs;
              r_cnt    <= CNT_W'(WIDTH - 1);
              r_is_rem <= op[1];
              if (w_special) begin
                // Raw results, no sign correction
                r_neg_q <= 1'b0;
                r_neg_r <= 1'b0;
                r_quo   <= w_div_zero ? W_ONES : W_MIN;
                r_rem   <= w_div_zero ? dividend : '0;
              end else begin
                r_neg_q <= w_dvd_neg ^ w_dsr_neg;
                r_neg_r <= w_dvd_neg;
                r_quo   <= '0;
                r_rem   <= '0;
              end
            end
          end
          S_CMP: begin
            r_rem <= w_shifted;
            r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
            r_quo <= {r_quo[WIDTH-2:0], ~alu_ltu};
            if (alu_ltu && !w_last) r_cnt <= r_cnt - CNT_W'(1);
          end
          S_SUB: begin
            r_rem <= alu_result;
            if (!w_last) r_cnt <= r_cnt - CNT_W'(1);
          end
          S_FIN: begin
            if (r_is_rem) result <= r_neg_r ? (~r_rem + WIDTH'(1)) : r_rem;
            else          result <= r_neg_q ? (~r_quo + WIDTH'(1)) : r_quo;
            done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_div_sequencer.sv
// Testbench for alu_div_sequencer: bench-side ALU, arithmetic reference model,
// per-cycle output comparison and directed vectors with literal expectations.
module tb_alu_div_sequencer;

  localparam logic [3:0] A_ADD = 4'd0;
  localparam logic [3:0] A_SUB = 4'd1;
  localparam logic [3:0] A_LTU = 4'd2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_ltu;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_div_sequencer #(.WIDTH(32), .FAST_SPEC(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .dividend(dividend), .divisor(divisor), .flush(flush),
    .busy(busy), .done(done), .result(result),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_ltu(alu_ltu)
  );

  // Shared ALU as seen by the sequencer
  assign alu_result = alu_a - alu_b;
  assign alu_ltu    = (alu_a < alu_b);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference arithmetic
  function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] mag(input logic [1:0] o, input logic [31:0] x);
    return (!o[0] && x[31]) ? 32'd0 - x : x;
  endfunction

  function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (o[0]) return o[1] ? a % b : a / b;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
    sa = $signed(a);
    sb = $signed(b);
    return o[1] ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  // Behavioural model: busy window, done pulse, held result, ALU op counts
  logic        m_busy, m_done;
  logic [31:0] m_res, m_pend, m_dsr;
  int          m_left, m_ltu, m_sub, m_exp_ltu, m_exp_sub;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_res <= '0; m_pend <= '0; m_dsr <= '0;
      m_left <= 0; m_ltu <= 0; m_sub <= 0; m_exp_ltu <= 0; m_exp_sub <= 0;
    end else begin
      m_done <= 1'b0;
      if (flush) begin
        m_busy <= 1'b0;
      end else if (!m_busy && start) begin
        m_busy <= 1'b1;
        m_pend <= ref_res(op, dividend, divisor);
        m_dsr  <= mag(op, divisor);
        m_ltu  <= 0;
        m_sub  <= 0;
        if (is_special(op, dividend, divisor)) begin
          m_left <= 1; m_exp_ltu <= 0; m_exp_sub <= 0;
        end else begin
          m_left    <= 33 + $countones(mag(op, dividend) / mag(op, divisor));
          m_exp_ltu <= 32;
          m_exp_sub <= $countones(mag(op, dividend) / mag(op, divisor));
        end
      end else if (m_busy) begin
        m_ltu  <= m_ltu + ((alu_op == A_LTU) ? 1 : 0);
        m_sub  <= m_sub + ((alu_op == A_SUB) ? 1 : 0);
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_res  <= m_pend;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("result", result, m_res);
      if (!m_busy) begin
        chk("idle_alu_op", 32'(alu_op), 32'(A_ADD));
        chk("idle_alu_a", alu_a, 32'd0);
        chk("idle_alu_b", alu_b, 32'd0);
      end
      if (alu_op == A_LTU || alu_op == A_SUB) chk("alu_b_dsr", alu_b, m_dsr);
      if (m_done) begin
        chk("ltu_cycles", 32'(m_ltu), 32'(m_exp_ltu));
        chk("sub_cycles", 32'(m_sub), 32'(m_exp_sub));
      end
    end
  end

  // Issue one op (current cycle is the start cycle), wait for done, check
  // latency and result against hand-computed literals. Optional ignored
  // second start at cycle extra_at.
  task automatic run(input string nm, input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp_res,
                     input int exp_lat, input int extra_at);
    int n;
    bit got;
    start = 1'b1; op = o; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; got = 1'b0;
    while (!got && n < 200) begin
      @(posedge clk); n++; #1;
      start = 1'b0;
      if (done) got = 1'b1;
      else if (extra_at != 0 && n == extra_at) begin
        start = 1'b1; op = 2'b01; dividend = 32'd50; divisor = 32'd3;
      end
    end
    if (!got) chk({nm, "_timeout"}, 32'd0, 32'd1);
    else begin
      chk({nm, "_lat"}, 32'(n), 32'(exp_lat));
      chk({nm, "_res"}, result, exp_res);
    end
  endtask

  initial begin
    bit seen_done;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; dividend = '0; divisor = '0; flush = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run("divu_100_7",   2'b01, 32'd100,        32'd7,          32'd14,         36, 0);
    run("remu_100_7",   2'b11, 32'd100,        32'd7,          32'd2,          36, 0);
    run("div_m100_7",   2'b00, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  36, 0);
    run("rem_m100_7",   2'b10, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  36, 0);
    run("rem_100_m7",   2'b10, 32'd100,        32'hFFFF_FFF9,  32'd2,          36, 0);
    run("div_7_m1",     2'b00, 32'd7,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  36, 0);
    run("divu_0_5",     2'b01, 32'd0,          32'd5,          32'd0,          33, 0);
    run("divu_by0",     2'b01, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  1,  0);
    run("remu_by0",     2'b11, 32'h1234_5678,  32'd0,          32'h1234_5678,  1,  0);
    run("div_ovf",      2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  0);
    run("rem_ovf",      2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1,  0);
    run("divu_max_1",   2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  65, 10);
    run("remu_by0_b",   2'b11, 32'h1234_5678,  32'd0,          32'h1234_5678,  1,  0);

    // Flush in the middle of a divide
    start = 1'b1; op = 2'b01; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_result", result, 32'h1234_5678);
    seen_done = 1'b0;
    repeat (40) begin @(posedge clk); #1; seen_done |= done; end
    chk("flush_no_done", 32'(seen_done), 32'd0);
    chk("flush_result_held", result, 32'h1234_5678);

    // Reset pulse mid-operation
    start = 1'b1; op = 2'b01; dividend = 32'hFFFF_FFFF; divisor = 32'd1;
    @(posedge clk); #1 start = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_result", result, 32'd0);
    chk("mrst_alu_op", 32'(alu_op), 32'd0);
    chk("mrst_alu_a", alu_a, 32'd0);
    chk("mrst_alu_b", alu_b, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run("divu_after_rst", 2'b01, 32'd100, 32'd7, 32'd14, 36, 0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
